// File: rtl/safecrack_code_sender_if.sv
// Control and lock-side signals of the safecrack code sender.
// master = the sender itself, slave = whoever requests codes and hosts the lock.
interface safecrack_code_sender_if;
  logic       start;
  logic       abort;
  logic [3:0] code0;
  logic [3:0] code1;
  logic [3:0] code2;
  logic       unlocked;
  logic [3:0] btn;
  logic       busy;
  logic       done;
  logic       success;

  modport master (
    input  start, abort, code0, code1, code2, unlocked,
    output btn, busy, done, success
  );

  modport slave (
    output start, abort, code0, code1, code2, unlocked,
    input  btn, busy, done, success
  );
endinterface

// File: rtl/safecrack_code_sender.sv
// Plays a latched three-word code onto the lock's buttons with fixed hold/gap
// timing, then watches for the lock to open within a bounded window.
module safecrack_code_sender #(
  parameter int HOLD_CYCLES    = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  safecrack_code_sender_if.master bus
);

  localparam int MAX_HG   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_LOAD = (TIMEOUT_CYCLES > MAX_HG) ? TIMEOUT_CYCLES : MAX_HG;
  localparam int CW       = $clog2(MAX_LOAD + 1);

  // Counters are loaded with (length - 1) and the phase ends when they reach zero.
  localparam logic [CW-1:0] HOLD_LD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LD = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    GAP   = 3'd2,
    WAIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t        state_reg;
  logic [1:0]    idx_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    btn_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          success_reg;

  logic [11:0]   code_in;
  logic [11:0]   code_words;
  logic          accept;
  logic [1:0]    idx_inc;
  logic          fin_now;
  logic          fin_result;

  assign code_in = {bus.code2, bus.code1, bus.code0};
  assign accept  = (state_reg == IDLE) && bus.start;
  assign idx_inc = idx_reg + 2'd1;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_code
      logic [3:0] word_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (accept) begin
          word_reg <= code_in[gi*4 +: 4];
        end
      end

      assign code_words[gi*4 +: 4] = word_reg;
    end
  endgenerate

  function automatic logic [3:0] pick_word(input logic [11:0] words, input logic [1:0] i);
    case (i)
      2'd0:    pick_word = words[3:0];
      2'd1:    pick_word = words[7:4];
      default: pick_word = words[11:8];
    endcase
  endfunction

  // Abort beats an unlocked that rises in the same WAIT cycle.
  always_comb begin
    fin_now    = 1'b0;
    fin_result = 1'b0;
    if (state_reg == DRIVE || state_reg == GAP || state_reg == WAIT) begin
      if (bus.abort) begin
        fin_now = 1'b1;
      end else if (state_reg == WAIT && bus.unlocked) begin
        fin_now    = 1'b1;
        fin_result = 1'b1;
      end else if (state_reg == WAIT && cnt_reg == '0) begin
        fin_now = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      btn_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      success_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (fin_now) begin
        state_reg   <= FIN;
        btn_reg     <= '0;
        busy_reg    <= 1'b0;
        done_reg    <= 1'b1;
        success_reg <= fin_result;
      end else begin
        case (state_reg)
          IDLE: begin
            btn_reg <= '0;
            if (bus.start) begin
              state_reg   <= DRIVE;
              idx_reg     <= '0;
              cnt_reg     <= HOLD_LD;
              btn_reg     <= bus.code0;
              busy_reg    <= 1'b1;
              success_reg <= 1'b0;
            end
          end
          DRIVE: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end else if (idx_reg == 2'd2) begin
              state_reg <= WAIT;
              cnt_reg   <= TIMEOUT_LD;
              btn_reg   <= '0;
            end else if (GAP_CYCLES == 0) begin
              idx_reg <= idx_inc;
              cnt_reg <= HOLD_LD;
              btn_reg <= pick_word(code_words, idx_inc);
            end else begin
              state_reg <= GAP;
              cnt_reg   <= GAP_LD;
              btn_reg   <= '0;
            end
          end
          GAP: begin
            if (cnt_reg != '0) begin
              cnt_reg <= cnt_reg - CNT_ONE;
            end else begin
              state_reg <= DRIVE;
              idx_reg   <= idx_inc;
              cnt_reg   <= HOLD_LD;
              btn_reg   <= pick_word(code_words, idx_inc);
            end
          end
          WAIT: begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
          FIN: begin
            state_reg <= IDLE;
            btn_reg   <= '0;
          end
          default: begin
            state_reg <= IDLE;
            btn_reg   <= '0;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.btn     = btn_reg;
  assign bus.busy    = busy_reg;
  assign bus.done    = done_reg;
  assign bus.success = success_reg;

endmodule

// File: tb/tb_safecrack_code_sender.sv
// Bench for safecrack_code_sender: two instances (gapped and back-to-back timing)
// share one stimulus stream and are compared each cycle against a timeline model.
module tb_safecrack_code_sender;

  localparam int H0 = 4, G0 = 2, T0 = 16;
  localparam int H1 = 1, G1 = 0, T1 = 5;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  safecrack_code_sender_if if0 ();
  safecrack_code_sender_if if1 ();

  safecrack_code_sender #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .TIMEOUT_CYCLES(T0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  safecrack_code_sender #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .TIMEOUT_CYCLES(T1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 running (t = cycle number since accept), 2 fin.
  int         m_mode [2];
  int         m_t    [2];
  logic [3:0] m_code [2][3];
  logic [3:0] e_btn  [2];
  logic       e_busy [2];
  logic       e_done [2];
  logic       e_succ [2];

  function automatic int p_h(input int d); return (d == 0) ? H0 : H1; endfunction
  function automatic int p_g(input int d); return (d == 0) ? G0 : G1; endfunction
  function automatic int p_t(input int d); return (d == 0) ? T0 : T1; endfunction

  function automatic logic [3:0] model_word(input int d, input int t);
    int hh, gg, p, k, r;
    hh = p_h(d);
    gg = p_g(d);
    if (t < 1 || t > 3*hh + 2*gg) return 4'h0;
    p = t - 1;
    k = p / (hh + gg);
    r = p % (hh + gg);
    return (r < hh) ? m_code[d][k] : 4'h0;
  endfunction

  task automatic model_reset(input int d);
    m_mode[d] = 0;
    m_t[d]    = 0;
    for (int i = 0; i < 3; i++) m_code[d][i] = 4'h0;
    e_btn[d]  = 4'h0;
    e_busy[d] = 1'b0;
    e_done[d] = 1'b0;
    e_succ[d] = 1'b0;
  endtask

  task automatic model_fin(input int d, input logic res);
    m_mode[d] = 2;
    e_done[d] = 1'b1;
    e_succ[d] = res;
    e_busy[d] = 1'b0;
    e_btn[d]  = 4'h0;
  endtask

  task automatic model_step(input int d, input logic s, input logic a, input logic u,
                            input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
    int seq_len;
    seq_len = 3*p_h(d) + 2*p_g(d);
    e_done[d] = 1'b0;
    case (m_mode[d])
      0: begin
        e_btn[d]  = 4'h0;
        e_busy[d] = 1'b0;
        if (s) begin
          m_code[d][0] = c0;
          m_code[d][1] = c1;
          m_code[d][2] = c2;
          m_mode[d] = 1;
          m_t[d]    = 1;
          e_busy[d] = 1'b1;
          e_succ[d] = 1'b0;
          e_btn[d]  = model_word(d, 1);
        end
      end
      1: begin
        if (a) begin
          model_fin(d, 1'b0);
        end else if (m_t[d] > seq_len) begin
          if (u) model_fin(d, 1'b1);
          else if (m_t[d] - seq_len >= p_t(d)) model_fin(d, 1'b0);
          else m_t[d] = m_t[d] + 1;
        end else begin
          m_t[d]   = m_t[d] + 1;
          e_btn[d] = model_word(d, m_t[d]);
        end
      end
      default: begin
        m_mode[d] = 0;
        e_btn[d]  = 4'h0;
        e_busy[d] = 1'b0;
      end
    endcase
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("btn0",  {28'd0, if0.btn},     {28'd0, e_btn[0]});
    check_val("busy0", {31'd0, if0.busy},    {31'd0, e_busy[0]});
    check_val("done0", {31'd0, if0.done},    {31'd0, e_done[0]});
    check_val("succ0", {31'd0, if0.success}, {31'd0, e_succ[0]});
    check_val("btn1",  {28'd0, if1.btn},     {28'd0, e_btn[1]});
    check_val("busy1", {31'd0, if1.busy},    {31'd0, e_busy[1]});
    check_val("done1", {31'd0, if1.done},    {31'd0, e_done[1]});
    check_val("succ1", {31'd0, if1.success}, {31'd0, e_succ[1]});
  endtask

  // Drive one cycle's inputs, let the edge close the cycle, then compare.
  task automatic tick(input logic s, input logic a, input logic u,
                      input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2);
    if0.start = s;  if1.start = s;
    if0.abort = a;  if1.abort = a;
    if0.unlocked = u; if1.unlocked = u;
    if0.code0 = c0; if1.code0 = c0;
    if0.code1 = c1; if1.code1 = c1;
    if0.code2 = c2; if1.code2 = c2;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) model_reset(d);
      else model_step(d, s, a, u, c0, c1, c2);
    end
    #1;
    check_outputs();
    if (if0.done) $display("txn dut0 done success=%0b t=%0t", if0.success, $time);
    if (if1.done) $display("txn dut1 done success=%0b t=%0t", if1.success, $time);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_btn0"},  {28'd0, if0.btn},     32'd0);
    check_val({tag, "_busy0"}, {31'd0, if0.busy},    32'd0);
    check_val({tag, "_done0"}, {31'd0, if0.done},    32'd0);
    check_val({tag, "_succ0"}, {31'd0, if0.success}, 32'd0);
    check_val({tag, "_btn1"},  {28'd0, if1.btn},     32'd0);
    check_val({tag, "_busy1"}, {31'd0, if1.busy},    32'd0);
  endtask

  int   done_cyc;
  int   done_cnt;
  logic r_s, r_a, r_u;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b1;
    if0.start = 1'b0; if0.abort = 1'b0; if0.unlocked = 1'b0;
    if0.code0 = 4'h0; if0.code1 = 4'h0; if0.code2 = 4'h0;
    if1.start = 1'b0; if1.abort = 1'b0; if1.unlocked = 1'b0;
    if1.code0 = 4'h0; if1.code1 = 4'h0; if1.code2 = 4'h0;
    for (int d = 0; d < 2; d++) model_reset(d);

    // Reset asserted before any clock edge must clear outputs on its own.
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset_initial");
    tick(0, 0, 0, 4'h0, 4'h0, 4'h0);
    tick(1, 0, 0, 4'h5, 4'h6, 4'h7);
    rst_n = 1'b0;
    tick(0, 0, 0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    tick(0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Default run: lock opens from cycle 9, expected done in cycle 18.
    tick(1, 0, 0, 4'b0111, 4'b1101, 4'b1101);
    done_cyc = -1;
    for (int c = 1; c <= 25; c++) begin
      tick(0, 0, (c >= 9), 4'h0, 4'h0, 4'h0);
      if (if0.done && done_cyc < 0) done_cyc = c + 1;
    end
    check_val("open_done_cycle", done_cyc, 32'd18);

    // Timeout run: expected done in cycle 33.
    tick(1, 0, 0, 4'b0111, 4'b1101, 4'b1101);
    done_cyc = -1;
    for (int c = 1; c <= 40; c++) begin
      tick(0, 0, 0, 4'h0, 4'h0, 4'h0);
      if (if0.done && done_cyc < 0) done_cyc = c + 1;
    end
    check_val("timeout_done_cycle", done_cyc, 32'd33);

    // Abort in GAP (cycle 5), restart with new codes in cycle 7.
    tick(1, 0, 0, 4'h3, 4'h9, 4'h0);
    done_cyc = -1;
    for (int c = 1; c <= 45; c++) begin
      tick((c == 7), (c == 5), 0,
           (c == 7) ? 4'hE : 4'h1, (c == 7) ? 4'h0 : 4'h2, (c == 7) ? 4'hA : 4'h4);
      if (if0.done && done_cyc < 0) done_cyc = c + 1;
    end
    check_val("abort_done_cycle", done_cyc, 32'd6);

    // Start pulse while busy with different codes must be ignored.
    tick(1, 0, 0, 4'hA, 4'hB, 4'hC);
    done_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      tick((c == 3), 0, 0, (c == 3) ? 4'h1 : 4'h0, (c == 3) ? 4'h2 : 4'h0, (c == 3) ? 4'h3 : 4'h0);
      if (if0.done) done_cnt++;
    end
    check_val("busy_start_done_count", done_cnt, 32'd1);

    // Asynchronous reset dropped between edges in cycle 2 of a run.
    tick(1, 0, 0, 4'h8, 4'h4, 4'h2);
    tick(0, 0, 0, 4'h0, 4'h0, 4'h0);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("reset_async");
    for (int d = 0; d < 2; d++) model_reset(d);
    tick(0, 0, 0, 4'h0, 4'h0, 4'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) tick(0, 0, 0, 4'h0, 4'h0, 4'h0);

    // Randomized traffic.
    r_u = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      r_s = ($urandom_range(0, 3) == 0);
      r_a = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 5) == 0) r_u = ~r_u;
      tick(r_s, r_a, r_u, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
